axi_aw_route_decoder: RTL
=========================

// Module: axi_aw_route_decoder
// PURPOSE
//  AW-channel router for one slave port (incoming master) of the AXI node; successor of the per-target AW decoder.
//  Decodes awaddr_i against N_REGION x N_INIT_PORT address windows and forwards AW to one init port.
//  Pushes the one-hot destination into the W-routing FIFO exactly once per burst.
//  Adds over the previous generation: per-port outstanding limits, same-destination ordering, optional default port.
//  Decode misses still go through drain -> absorb W -> error-B.
// PARAMETERS
//  ADDR_WIDTH      32  address width
//  N_INIT_PORT     8   number of init (master-side) ports
//  N_REGION        2   address windows per init port
//  MAX_OUTSTANDING 8   max in-flight AW per init port (>=1); CW=$clog2(MAX_OUTSTANDING+1)
//  DEFAULT_PORT_EN 0   1: decode miss routes to DEFAULT_PORT instead of error
//  DEFAULT_PORT    0   default init port index (<N_INIT_PORT)
// PORTS
//  clk                     in  1                  clock
//  rst_n                   in  1                  async reset, active low
//  awvalid_i               in  1                  AW valid from slave port
//  awaddr_i                in  ADDR_WIDTH         AW address
//  awready_o               out 1                  AW ready to slave port
//  awvalid_o               out N_INIT_PORT        one-hot AW valid to init ports
//  awready_i               in  N_INIT_PORT        AW ready from init ports
//  dest_push_o             out 1                  push into W destination FIFO
//  dest_o                  out N_INIT_PORT        one-hot destination pushed
//  dest_ready_i            in  1                  W destination FIFO not full
//  START_ADDR_i/END_ADDR_i in  N_REGION*N_INIT_PORT*ADDR_WIDTH  inclusive windows
//  enable_region_i         in  N_REGION*N_INIT_PORT  window enables
//  connectivity_map_i      in  N_INIT_PORT        allowed init ports
//  b_done_i                in  N_INIT_PORT        B handshake completed for port p (1 cycle)
//  error_req_o             out 1                  request error-B slot from B allocator
//  error_gnt_i             in  1                  error-B granted
//  handle_error_o          out 1                  W path: absorb data of errored burst
//  wdata_error_completed_i in  1                  errored burst WLAST absorbed
//  sample_awdata_info_o    out 1                  capture ID/len of errored AW (1 cycle)
// BEHAVIOUR
//  Decode (comb):
//  - hit[p] = OR over regions of enable & START<=addr<=END (unsigned, inclusive), masked by connectivity_map_i.
//  - Multiple hits: lowest p wins.
//  - No hit: DEFAULT_PORT_EN && connectivity_map_i[DEFAULT_PORT] selects DEFAULT_PORT; otherwise miss.
//  Counters:
//  - cnt[p] (CW bits, reset 0): +1 on AW handshake to p; -1 on b_done_i[p]; both same cycle -> unchanged.
//  - Never exceeds MAX_OUTSTANDING; b_done_i with cnt==0 is ignored (no underflow).
//  Ordering:
//  - last_dest (reset 0) = port of last accepted AW.
//  - New AW to sel != last_dest stalls while any cnt != 0.
//  States: OPERATIVE, FWD, DRAIN, ERR_WDATA, ERR_RESP; reset -> OPERATIVE.
//  - OPERATIVE: when awvalid_i & hit & dest_ready_i & cnt[sel]<MAX & ordering ok -> latch sel,
//    assert dest_push_o=1 with dest_o=onehot(sel), awvalid_o[sel]=1, awready_o=awready_i[sel].
//    If awready_i[sel]=1: handshake, stay OPERATIVE; else -> FWD.
//  - OPERATIVE on miss (awvalid_i & no route): awready_o=1 and sample_awdata_info_o=1 for one cycle,
//    no push, no awvalid_o -> DRAIN.
//  - FWD: hold awvalid_o[latched]=1 (independent of dest_ready_i/addr); awready_o=awready_i[latched];
//    no further push. On handshake -> OPERATIVE.
//  - DRAIN: awready_o=0; all cnt==0 -> ERR_WDATA.
//  - ERR_WDATA: handle_error_o=1; wdata_error_completed_i -> ERR_RESP.
//  - ERR_RESP: error_req_o=1; error_gnt_i -> OPERATIVE.
//  Handshake/validity rules:
//  - awvalid_o never depends on awready_i; exactly one dest push per forwarded burst.
//  - Error bursts never pushed.
//  Reset:
//  - All outputs 0; counters 0; last_dest 0; async reset mid-burst drops the latched AW without a push.
//  - Unused states -> OPERATIVE.
// TESTING
//  1. Region0 port2 = [0x1000,0x1FFF]; AW 0x1800, awready_i[2]=1 -> same cycle: awvalid_o=0x04, dest_push_o=1,
//     dest_o=0x04, cnt[2]=1.
//  2. Same AW, awready_i[2] low 3 cycles -> awvalid_o held 4 cycles, dest_push_o high only in the first.
//  3. MAX_OUTSTANDING=2; 3 AWs to port 2, no b_done -> third stalls (awready_o=0).
//     b_done_i[2] pulse -> third accepted next cycle.
//  4. cnt[2]=1, AW to port 5 -> stalled until b_done_i[2]; then forwarded to port 5, last_dest=5.
//  5. Miss 0xF000_0000, DEFAULT_PORT_EN=0, cnt[1]=2 -> awready_o=1 one cycle, sample_awdata_info_o=1, DRAIN.
//     2x b_done_i[1] -> handle_error_o; wdata_error_completed_i -> error_req_o; error_gnt_i -> OPERATIVE.
//  6. Same miss with DEFAULT_PORT_EN=1, DEFAULT_PORT=3 -> awvalid_o=0x08, dest_o=0x08, no error.

Source files
------------

// File: rtl/axi_aw_route_decoder.sv
// AW-channel router for one slave port: decodes the address into a one-hot init port,
// enforces per-port outstanding limits and same-destination ordering, and steers decode misses to the error path.
module axi_aw_route_decoder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int N_INIT_PORT     = 8,
    parameter int N_REGION        = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int DEFAULT_PORT_EN = 0,
    parameter int DEFAULT_PORT    = 0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      awvalid_i,
    input  logic [ADDR_WIDTH-1:0]                     awaddr_i,
    output logic                                      awready_o,
    output logic [N_INIT_PORT-1:0]                    awvalid_o,
    input  logic [N_INIT_PORT-1:0]                    awready_i,
    output logic                                      dest_push_o,
    output logic [N_INIT_PORT-1:0]                    dest_o,
    input  logic                                      dest_ready_i,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
    input  logic [N_REGION*N_INIT_PORT-1:0]           enable_region_i,
    input  logic [N_INIT_PORT-1:0]                    connectivity_map_i,
    input  logic [N_INIT_PORT-1:0]                    b_done_i,
    output logic                                      error_req_o,
    input  logic                                      error_gnt_i,
    output logic                                      handle_error_o,
    input  logic                                      wdata_error_completed_i,
    output logic                                      sample_awdata_info_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

    localparam logic [2:0] ST_OPERATIVE = 3'd0;
    localparam logic [2:0] ST_FWD       = 3'd1;
    localparam logic [2:0] ST_DRAIN     = 3'd2;
    localparam logic [2:0] ST_ERR_WDATA = 3'd3;
    localparam logic [2:0] ST_ERR_RESP  = 3'd4;

    logic [2:0]             state;
    logic [2:0]             state_next;
    logic [PW-1:0]          sel;
    logic [PW-1:0]          fwd_port;
    logic [PW-1:0]          last_dest;
    logic                   found;
    logic [N_INIT_PORT-1:0] hit;
    logic [N_INIT_PORT-1:0] aw_valid;
    logic [N_INIT_PORT-1:0] sel_onehot;
    logic [N_INIT_PORT-1:0] fwd_onehot;
    logic [N_INIT_PORT-1:0] cnt_inc;
    logic [N_INIT_PORT-1:0] cnt_dec;
    logic [CW-1:0]          cnt [N_INIT_PORT];
    logic                   any_busy;
    logic                   cnt_ok;
    logic                   order_ok;
    logic                   fire;
    logic                   miss;

    // Descending scan so the lowest hitting port is the one left in sel.
    always_comb begin
        hit = '0;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            for (int r = 0; r < N_REGION; r++) begin
                if (enable_region_i[r*N_INIT_PORT+p] &&
                    START_ADDR_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH] <= awaddr_i &&
                    awaddr_i <= END_ADDR_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    hit[p] = 1'b1;
                end
            end
        end
        hit = hit & connectivity_map_i;
        sel = '0;
        for (int p = N_INIT_PORT - 1; p >= 0; p--) begin
            if (hit[p]) begin
                sel = PW'(p);
            end
        end
        found = |hit;
        if (!found && (DEFAULT_PORT_EN != 0) && connectivity_map_i[DEFAULT_PORT]) begin
            sel   = PW'(DEFAULT_PORT);
            found = 1'b1;
        end
    end

    always_comb begin
        any_busy = 1'b0;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            if (cnt[p] != '0) begin
                any_busy = 1'b1;
            end
        end
    end

    assign sel_onehot = N_INIT_PORT'(1) << sel;
    assign fwd_onehot = N_INIT_PORT'(1) << fwd_port;
    assign cnt_ok     = cnt[sel] < CW'(MAX_OUTSTANDING);
    assign order_ok   = (sel == last_dest) || !any_busy;
    assign fire       = (state == ST_OPERATIVE) && awvalid_i && found && dest_ready_i && cnt_ok && order_ok;
    assign miss       = (state == ST_OPERATIVE) && awvalid_i && !found;

    assign aw_valid             = fire ? sel_onehot : ((state == ST_FWD) ? fwd_onehot : '0);
    assign awvalid_o            = aw_valid;
    assign awready_o            = fire ? awready_i[sel] : ((state == ST_FWD) ? awready_i[fwd_port] : miss);
    assign dest_push_o          = fire;
    assign dest_o               = fire ? sel_onehot : '0;
    assign sample_awdata_info_o = miss;
    assign handle_error_o       = (state == ST_ERR_WDATA);
    assign error_req_o          = (state == ST_ERR_RESP);

    always_comb begin
        state_next = state;
        case (state)
            ST_OPERATIVE: begin
                if (fire && !awready_i[sel]) begin
                    state_next = ST_FWD;
                end else if (miss) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_FWD:       if (awready_i[fwd_port]) state_next = ST_OPERATIVE;
            ST_DRAIN:     if (!any_busy) state_next = ST_ERR_WDATA;
            ST_ERR_WDATA: if (wdata_error_completed_i) state_next = ST_ERR_RESP;
            ST_ERR_RESP:  if (error_gnt_i) state_next = ST_OPERATIVE;
            default:      state_next = ST_OPERATIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OPERATIVE;
            fwd_port  <= '0;
            last_dest <= '0;
        end else begin
            state <= state_next;
            if (fire) begin
                fwd_port  <= sel;
                last_dest <= sel;
            end
        end
    end

    // A B completion on an idle port is dropped so the count cannot wrap.
    always_comb begin
        cnt_inc = aw_valid & awready_i;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            cnt_dec[p] = b_done_i[p] && (cnt[p] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < N_INIT_PORT; p++) begin
                cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N_INIT_PORT; p++) begin
                if (cnt_inc[p] && !cnt_dec[p]) begin
                    cnt[p] <= cnt[p] + CW'(1);
                end else if (cnt_dec[p] && !cnt_inc[p]) begin
                    cnt[p] <= cnt[p] - CW'(1);
                end
            end
        end
    end

endmodule
